// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, buffer entry layout and the NOP filler word.
package cpu_types;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_REQ,
      FETCH_WAIT,
      FETCH_DROP
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; flush wins over push and pop.
module fetch_buffer
   import cpu_types::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  fetch_entry_t               push_entry,
   input  logic                       pop,
   input  logic                       flush,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(BUF_DEPTH):0] count,
   output fetch_entry_t               head
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(BUF_DEPTH);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   fetch_entry_t  mem_q [BUF_DEPTH];
   fetch_entry_t  mem_d [BUF_DEPTH];
   logic          push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_C);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time and buffers words for decode.
// Define FETCH_STALL_COUNT_EN to add the stall_cycles counter output.
//
// state | meaning
// IDLE  | first cycle after reset release
// REQ   | presenting pc to imem while buffer has room
// WAIT  | request accepted, response will be buffered
// DROP  | request accepted, redirect seen since; response will be discarded
module instruction_fetch
   import cpu_types::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] instruction,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
`ifdef FETCH_STALL_COUNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

   fetch_state_t  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          req_hs, push, pop;
   logic          buf_full, buf_empty;
   logic [CW-1:0] buf_count;
   fetch_entry_t  buf_head, push_entry;

   assign imem_req_valid = (state_q == FETCH_REQ) && (buf_count < DEPTH_C);
   assign imem_addr      = pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign inst_valid     = !buf_empty;
   assign instruction    = buf_empty ? NOP_INSTRUCTION : buf_head.instr;
   assign inst_pc        = buf_empty ? 32'h0 : buf_head.pc;
   assign pop            = inst_valid && inst_ready && !redirect_valid;
   assign push_entry     = '{pc: req_pc_q, instr: imem_rsp_data};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      push     = 1'b0;
      case (state_q)
         FETCH_IDLE: state_d = FETCH_REQ;
         FETCH_REQ: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = req_hs ? FETCH_DROP : FETCH_REQ;
            end else if (req_hs) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = imem_rsp_valid ? FETCH_REQ : FETCH_DROP;
            end else if (imem_rsp_valid) begin
               push    = !buf_full;
               state_d = FETCH_REQ;
            end
         end
         FETCH_DROP: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end
            // The response for the abandoned request ends the drop even if a new redirect lands with it.
            if (imem_rsp_valid) begin
               state_d = FETCH_REQ;
            end
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FETCH_IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_fetch_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .full       (buf_full),
      .empty      (buf_empty),
      .count      (buf_count),
      .head       (buf_head)
   );

`ifdef FETCH_STALL_COUNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (inst_ready && !inst_valid && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front of the datapath, directly upstream of the control unit.
- Owns the architectural PC and issues word fetches to instruction memory over a valid/ready request and valid-only response interface.
- Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts redirects (taken branches, jumps) from the execute stage and flushes wrong-path instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  byte address of the requested word.
- imem_rsp_valid  in  1  response word valid; one cycle pulse per accepted request.
- imem_rsp_data  in  32  fetched instruction.
- inst_valid  out  1  buffer head is valid.
- inst_ready  in  1  decode consumes the head.
- instruction  out  32  head instruction, fed to control_unit.instruction.
- inst_pc  out  32  PC of the head instruction.
- redirect_valid  in  1  redirect fetch; one cycle pulse.
- redirect_pc  in  32  redirect target; word aligned.

Behaviour:
- Reset is asynchronous, active-low.
- Reset values:
  - state=IDLE, pc=RESET_PC, buffer empty (count=0).
  - imem_req_valid=0, inst_valid=0, imem_addr=RESET_PC.
  - instruction=32'h0000_0013 (NOP), inst_pc=0.
- FSM states are IDLE, REQ, WAIT and DROP.
  - IDLE goes to REQ on the first clock after rst_n deasserts.
  - REQ: imem_req_valid=(count<BUF_DEPTH), imem_addr=pc. On handshake (valid&&ready): pc<=pc+4, go to WAIT.
  - WAIT: imem_req_valid=0. When imem_rsp_valid is high, push {pc_of_request, imem_rsp_data} and go to REQ.
  - DROP: imem_req_valid=0. When imem_rsp_valid is high, discard the response and go to REQ.
- At most one request is outstanding, so peak throughput is one instruction per 2 cycles.
- Latency: a response at cycle N gives inst_valid at N+1 (registered push), provided the buffer was empty.
- Request PCs:
  - The PC of each outstanding request is held in a register (req_pc).
  - A 32-bit pc wraps 32'hFFFF_FFFC -> 0 silently.
- Output handshake:
  - instruction and inst_pc are driven from the FIFO head.
  - A pop occurs when inst_valid&&inst_ready.
  - A push and a pop in the same cycle are both allowed; count stays unchanged.
  - A push while full cannot occur: REQ only asserts imem_req_valid when count<BUF_DEPTH, which also counts the outstanding slot.
- Redirect has priority over every other event in its cycle:
  - Buffer is flushed (count<=0) and pc<=redirect_pc. A pop in the same cycle is ignored.
  - REQ without handshake: the request is withdrawn; the memory tolerates withdrawal. Go to REQ, and imem_addr=redirect_pc next cycle.
  - REQ with handshake in the same cycle: go to DROP.
  - WAIT without imem_rsp_valid: go to DROP.
  - WAIT with imem_rsp_valid in the same cycle: discard that response and go to REQ.
  - DROP: stay in DROP with the new pc.
- Reset mid-operation: all state returns to reset values immediately. Any response to a pre-reset request arriving afterwards is ignored, because the FSM is in IDLE or REQ.

Optional Feature:
- Macro FETCH_STALL_COUNT_EN.
- Defined:
  - Adds output port stall_cycles (32 bits).
  - Counts cycles with inst_ready=1 and inst_valid=0.
  - Reset to 0; saturates at 32'hFFFF_FFFF.
  - Redirect does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package cpu_types gains:
  - typedef fetch_state_t {FETCH_IDLE, FETCH_REQ, FETCH_WAIT, FETCH_DROP}.
  - Constant NOP_INSTRUCTION = 32'h0000_0013.
- Sub-module fetch_buffer:
  - Synchronous FIFO, parameter BUF_DEPTH, 64-bit entries {pc, instr}.
  - Ports: push, pop, flush, full, empty, count, head.
  - flush has priority over push and pop.

Test Plan:
- Reset, imem ready=1, 1-cycle response, inst_ready=1 -> requests at addresses 0,4,8; instructions appear with inst_pc 0,4,8; one every 2 cycles.
- inst_ready=0 with BUF_DEPTH=2 -> exactly 2 entries buffered (PCs 0,4), then imem_req_valid stays 0. inst_ready=1 -> pops in order and fetch resumes at 8.
- redirect_pc=32'h100 while in WAIT for addr 8 -> response for 8 is dropped, buffer flushed, next request addr 32'h100, next inst_pc 32'h100.
- redirect_pc=32'h200 in the same cycle as imem_rsp_valid -> response discarded, no inst_valid for it, next request addr 32'h200.
- imem_req_ready=0 for 3 cycles, then redirect to 32'h40 -> imem_addr switches to 32'h40, pc not incremented, no DROP.
- rst_n low mid-WAIT, late imem_rsp_valid after release -> ignored; first request addr is RESET_PC. With FETCH_STALL_COUNT_EN, stall_cycles counts exactly the empty-ready cycles.
